// File: rtl/axi4lite_mem_responder.sv
// AXI4-Lite slave word memory for an mriscvcore initiator port.
// Independent read/write channels, fixed read latency, byte-strobed writes.
module axi4lite_mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        AWvalid,
    output logic        AWready,
    input  logic [31:0] AWdata,
    input  logic [2:0]  AWprot,
    input  logic        Wvalid,
    output logic        Wready,
    input  logic [31:0] Wdata,
    input  logic [3:0]  Wstrb,
    output logic        Bvalid,
    input  logic        Bready,
    input  logic        ARvalid,
    output logic        ARready,
    input  logic [31:0] ARdata,
    input  logic [2:0]  ARprot,
    output logic        Rvalid,
    input  logic        RReady,
    output logic [31:0] Rdata
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [7:0] LAT_M1 = 8'(READ_LAT - 1);

    typedef enum logic {W_COLLECT, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;

    logic [31:0] mem_q [DEPTH];

    w_state_e               w_state_q, w_state_d;
    logic                   aw_held_q, aw_held_d;
    logic                   w_held_q, w_held_d;
    logic                   awready_q, awready_d;
    logic                   wready_q, wready_d;
    logic                   bvalid_q, bvalid_d;
    logic [ADDR_BITS-1:0]   widx_q, widx_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wstrb_q, wstrb_d;
    logic                   mem_we;

    r_state_e               r_state_q, r_state_d;
    logic                   arready_q, arready_d;
    logic                   rvalid_q, rvalid_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [ADDR_BITS-1:0]   ridx_q, ridx_d;
    logic [7:0]             cnt_q, cnt_d;

    logic unused_ok;
    assign unused_ok = ^{AWprot, ARprot, AWdata[31:ADDR_BITS+2], AWdata[1:0],
                         ARdata[31:ADDR_BITS+2], ARdata[1:0]};

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        widx_d    = widx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        mem_we    = 1'b0;
        unique case (w_state_q)
            W_COLLECT: begin
                if (AWvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    widx_d    = AWdata[ADDR_BITS+1:2];
                end
                if (Wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = Wdata;
                    wstrb_d  = Wstrb;
                end
                awready_d = !aw_held_d;
                wready_d  = !w_held_d;
                // Both halves held: commit now and keep readies low until B completes
                if (aw_held_q && w_held_q) begin
                    mem_we    = 1'b1;
                    bvalid_d  = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (Bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_COLLECT;
                end
            end
            default: w_state_d = W_COLLECT;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        ridx_d    = ridx_q;
        cnt_d     = cnt_q;
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ARvalid && arready_q) begin
                    arready_d = 1'b0;
                    ridx_d    = ARdata[ADDR_BITS+1:2];
                    cnt_d     = LAT_M1;
                    if (READ_LAT == 1) begin
                        rvalid_d  = 1'b1;
                        rdata_d   = mem_q[ARdata[ADDR_BITS+1:2]];
                        r_state_d = R_RESP;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = mem_q[ridx_q];
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (RReady) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_COLLECT;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            widx_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            ridx_q    <= '0;
            cnt_q     <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            widx_q    <= widx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            ridx_q    <= ridx_d;
            cnt_q     <= cnt_d;
        end
    end

    // Array has no reset so its contents survive rstn
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem_q[widx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign AWready = awready_q;
    assign Wready  = wready_q;
    assign Bvalid  = bvalid_q;
    assign ARready = arready_q;
    assign Rvalid  = rvalid_q;
    assign Rdata   = rdata_q;

endmodule

// File: tb/tb_axi4lite_mem_responder.sv
// Bench for axi4lite_mem_responder: two instances (read latency 1 and 4),
// vector table, hand sequences and random traffic against a word-array model.
module tb_axi4lite_mem_responder;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        awvalid [2];
    logic        awready [2];
    logic [31:0] awaddr  [2];
    logic        wvalid  [2];
    logic        wready  [2];
    logic [31:0] wdata   [2];
    logic [3:0]  wstrb   [2];
    logic        bvalid  [2];
    logic        bready  [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] araddr  [2];
    logic        rvalid  [2];
    logic        rready  [2];
    logic [31:0] rdata   [2];
    logic [2:0]  prot;

    axi4lite_mem_responder #(.ADDR_BITS(10), .READ_LAT(1)) dut0 (
        .clk(clk), .rstn(rstn),
        .AWvalid(awvalid[0]), .AWready(awready[0]), .AWdata(awaddr[0]), .AWprot(prot),
        .Wvalid(wvalid[0]), .Wready(wready[0]), .Wdata(wdata[0]), .Wstrb(wstrb[0]),
        .Bvalid(bvalid[0]), .Bready(bready[0]),
        .ARvalid(arvalid[0]), .ARready(arready[0]), .ARdata(araddr[0]), .ARprot(prot),
        .Rvalid(rvalid[0]), .RReady(rready[0]), .Rdata(rdata[0])
    );

    axi4lite_mem_responder #(.ADDR_BITS(10), .READ_LAT(4)) dut1 (
        .clk(clk), .rstn(rstn),
        .AWvalid(awvalid[1]), .AWready(awready[1]), .AWdata(awaddr[1]), .AWprot(prot),
        .Wvalid(wvalid[1]), .Wready(wready[1]), .Wdata(wdata[1]), .Wstrb(wstrb[1]),
        .Bvalid(bvalid[1]), .Bready(bready[1]),
        .ARvalid(arvalid[1]), .ARready(arready[1]), .ARdata(araddr[1]), .ARprot(prot),
        .Rvalid(rvalid[1]), .RReady(rready[1]), .Rdata(rdata[1])
    );

    int n_chk = 0;
    int n_pass = 0;
    int exp_lat [2];
    logic [31:0] ref_mem [2][1024];

    typedef struct {
        int          d;
        logic [31:0] waddr;
        logic [31:0] wdat;
        logic [3:0]  strb;
        int          awd;
        int          wd;
        int          bd;
        logic [31:0] raddr;
        int          rd;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        $display("FAIL %s: timed out", nm);
    endtask

    task automatic write_txn(input int d, input logic [31:0] a, input logic [31:0] dt,
                             input logic [3:0] s, input int awd, input int wd, input int bd);
        bit awdone = 0;
        bit wdone = 0;
        int cyc = 0;
        while (!(awdone && wdone) && cyc < 40) begin
            awvalid[d] = !awdone && cyc >= awd;
            awaddr[d]  = a;
            wvalid[d]  = !wdone && cyc >= wd;
            wdata[d]   = dt;
            wstrb[d]   = s;
            if (awvalid[d] && awready[d]) awdone = 1;
            if (wvalid[d] && wready[d]) wdone = 1;
            @(negedge clk);
            cyc++;
            if (wdone && !awdone) chk("wready_after_w", wready[d], 0);
            if (awdone && !wdone) chk("awready_after_aw", awready[d], 0);
        end
        awvalid[d] = 0;
        wvalid[d]  = 0;
        if (!(awdone && wdone)) timeout("wr_accept");
        chk("bvalid_before_commit", bvalid[d], 0);
        @(negedge clk);
        chk("bvalid_after_capture", bvalid[d], 1);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[d][a[11:2]][8*b +: 8] = dt[8*b +: 8];
        for (int i = 0; i < bd; i++) begin
            chk("bvalid_hold", bvalid[d], 1);
            chk("awready_in_resp", awready[d], 0);
            chk("wready_in_resp", wready[d], 0);
            @(negedge clk);
        end
        bready[d] = 1;
        @(negedge clk);
        bready[d] = 0;
        chk("bvalid_clear", bvalid[d], 0);
        chk("awready_back", awready[d], 1);
        chk("wready_back", wready[d], 1);
    endtask

    task automatic read_txn(input int d, input logic [31:0] a, input int rd,
                            output logic [31:0] data);
        int cyc = 0;
        int lat = 1;
        arvalid[d] = 1;
        araddr[d]  = a;
        while (!arready[d] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!arready[d]) timeout("rd_accept");
        @(negedge clk);
        arvalid[d] = 0;
        while (!rvalid[d] && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("rd_latency_d%0d", d), lat, exp_lat[d]);
        data = rdata[d];
        for (int i = 0; i < rd; i++) begin
            chk("rvalid_hold", rvalid[d], 1);
            chk("rdata_stable", rdata[d], data);
            chk("arready_in_resp", arready[d], 0);
            @(negedge clk);
        end
        rready[d] = 1;
        @(negedge clk);
        rready[d] = 0;
        chk("rvalid_clear", rvalid[d], 0);
        chk("arready_back", arready[d], 1);
        chk("rdata_kept", rdata[d], data);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        int w;
        exp_lat[0] = 1;
        exp_lat[1] = 4;
        prot = 3'b0;
        for (int d = 0; d < 2; d++) begin
            awvalid[d] = 0; awaddr[d] = 0; wvalid[d] = 0; wdata[d] = 0;
            wstrb[d] = 0; bready[d] = 0; arvalid[d] = 0; araddr[d] = 0; rready[d] = 0;
        end
        vt[0] = '{0, 32'h10,   32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h10,        0, 32'hDEADBEEF};
        vt[1] = '{0, 32'h20,   32'hAABBCCDD, 4'hF, 1, 0, 0, 32'h20,        0, 32'hAABBCCDD};
        vt[2] = '{0, 32'h20,   32'h11223344, 4'h5, 3, 0, 0, 32'h20,        1, 32'hAA22CC44};
        vt[3] = '{1, 32'h30,   32'h12345678, 4'hF, 0, 2, 4, 32'h30,        5, 32'h12345678};
        vt[4] = '{1, 32'h30,   32'hCAFEF00D, 4'h8, 2, 2, 0, 32'h33,        0, 32'hCA345678};
        vt[5] = '{1, 32'h1000, 32'h00000005, 4'hF, 0, 0, 1, 32'h0,         5, 32'h00000005};
        vt[6] = '{0, 32'h44,   32'h01020304, 4'hF, 0, 1, 0, 32'h44,        0, 32'h01020304};
        vt[7] = '{0, 32'h44,   32'hFFFFFFFF, 4'h0, 0, 0, 2, 32'hFFFFF047,  2, 32'h01020304};

        rstn = 0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_awready", awready[d], 0);
            chk("rst_wready", wready[d], 0);
            chk("rst_arready", arready[d], 0);
            chk("rst_bvalid", bvalid[d], 0);
            chk("rst_rvalid", rvalid[d], 0);
            chk("rst_rdata", rdata[d], 0);
        end
        rstn = 1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rel_awready", awready[d], 1);
            chk("rel_wready", wready[d], 1);
            chk("rel_arready", arready[d], 1);
        end

        for (int i = 0; i < 8; i++) begin
            write_txn(vt[i].d, vt[i].waddr, vt[i].wdat, vt[i].strb, vt[i].awd, vt[i].wd, vt[i].bd);
            read_txn(vt[i].d, vt[i].raddr, vt[i].rd, got);
            chk($sformatf("vec%0d_rdata", i), got, vt[i].exp);
        end

        // Same-edge collision on the latency-1 instance
        write_txn(0, 32'h50, 32'h11111111, 4'hF, 0, 0, 0);
        awvalid[0] = 1; awaddr[0] = 32'h50;
        wvalid[0] = 1; wdata[0] = 32'h22222222; wstrb[0] = 4'hF;
        @(negedge clk);
        awvalid[0] = 0; wvalid[0] = 0;
        chk("coll_arready", arready[0], 1);
        arvalid[0] = 1; araddr[0] = 32'h50;
        @(negedge clk);
        arvalid[0] = 0;
        chk("coll_bvalid", bvalid[0], 1);
        chk("coll_rvalid", rvalid[0], 1);
        chk("coll_old_data", rdata[0], 32'h11111111);
        ref_mem[0][20] = 32'h22222222;
        bready[0] = 1; rready[0] = 1;
        @(negedge clk);
        bready[0] = 0; rready[0] = 0;
        read_txn(0, 32'h50, 0, got);
        chk("coll_new_data", got, 32'h22222222);

        // Reset pulse while the latency-4 read is waiting
        chk("midrst_arready_pre", arready[1], 1);
        arvalid[1] = 1; araddr[1] = 32'h30;
        @(negedge clk);
        arvalid[1] = 0;
        rstn = 0;
        #1;
        chk("midrst_arready", arready[1], 0);
        chk("midrst_rvalid", rvalid[1], 0);
        chk("midrst_awready", awready[1], 0);
        @(negedge clk);
        rstn = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_rvalid", rvalid[1], 0);
        end
        chk("midrst_arready_back", arready[1], 1);
        read_txn(1, 32'h30, 0, got);
        chk("midrst_mem_kept", got, 32'hCA345678);

        // Random traffic against the word-array model
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++)
                write_txn(d, 32'(i) << 2, $urandom, 4'hF, 0, 0, 0);
            for (int n = 0; n < 60; n++) begin
                w = $urandom_range(0, 15);
                a = ($urandom & 32'hFFFFF000) | (32'(w) << 2) | ($urandom & 32'h3);
                prot = 3'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    write_txn(d, a, $urandom, 4'($urandom), $urandom_range(0, 3),
                              $urandom_range(0, 3), $urandom_range(0, 3));
                end else begin
                    read_txn(d, a, $urandom_range(0, 3), got);
                    chk($sformatf("rand_d%0d_w%0d", d, w), got, ref_mem[d][w]);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/axi4lite_mem_responder.md
Name: axi4lite_mem_responder

Overview:
- AXI4-Lite slave memory that answers the read/write initiator port of an mriscvcore instance.
- One instance per core in the dual-core S2QED top, so each copy gets an identical, independent memory.
- Single outstanding transaction per direction; the read and write channels are fully independent.
- Fixed, parameterised read latency; write responses are always OKAY (no resp fields on this interface).

Parameters:
- ADDR_BITS, 10, log2 of memory depth in 32-bit words (1024 words)
- READ_LAT, 1, cycles from AR handshake to Rvalid assertion; legal range 1..255

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- AWvalid  in  1  write address valid
- AWready  out  1  write address ready
- AWdata  in  32  write byte address
- AWprot  in  3  protection, ignored
- Wvalid  in  1  write data valid
- Wready  out  1  write data ready
- Wdata  in  32  write data
- Wstrb  in  4  byte strobes; bit i enables Wdata[8i+7:8i]
- Bvalid  out  1  write response valid
- Bready  in  1  write response ready
- ARvalid  in  1  read address valid
- ARready  out  1  read address ready
- ARdata  in  32  read byte address
- ARprot  in  3  protection, ignored
- Rvalid  out  1  read data valid
- RReady  in  1  read data ready
- Rdata  out  32  read data

Behaviour:
- Clock and reset: single clock clk; rstn is asynchronous, active-low.
- Reset values: AWready=0, Wready=0, ARready=0, Bvalid=0, Rvalid=0, Rdata=0. All readies are registered and rise on the first clk edge after rstn deasserts.
- Memory array is not reset; its contents survive rstn.
- Addressing: word index = addr[ADDR_BITS+1:2]. Bits [1:0] and bits above ADDR_BITS+1 are ignored, so addresses alias and wrap modulo 4*2^ADDR_BITS bytes.
- Handshake: a transfer occurs on a clk edge where valid&ready=1. Outputs depend only on registers (no combinational valid-to-ready path).
- Write FSM states: W_COLLECT, W_RESP.
  - W_COLLECT: AW and W are captured independently, in either order or in the same cycle.
  - AWready=1 until AW is captured, then 0. Wready behaves the same for W.
  - When both are held, the memory write commits on the next edge and Bvalid=1; go to W_RESP.
  - The write applies only the strobed bytes. Wstrb=0 writes nothing but still gets a response.
  - W_RESP: Bvalid held until Bready=1 at an edge. Then Bvalid=0, AWready=Wready=1, back to W_COLLECT.
  - A new AW/W is never accepted while Bvalid=1.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: ARready=1. On AR handshake, latch the word index, ARready=0, load counter=READ_LAT-1 (8-bit).
  - If READ_LAT=1, go straight to R_RESP. Otherwise go to R_WAIT, which decrements the counter and enters R_RESP at 0.
  - Rdata is loaded on the edge that sets Rvalid. Rdata and Rvalid then stay stable until RReady=1.
  - Read-to-valid latency is exactly READ_LAT cycles.
  - R_RESP: on Rvalid&RReady, Rvalid=0, ARready=1, back to R_IDLE. Rdata keeps its last value.
- Same-word collision: a read samples the array contents as they stand before any write committing on the same edge (old data). Later reads see the new data.
- Write→read ordering across channels is otherwise not enforced; the initiator orders by waiting for Bvalid.
- Backpressure: Bready or RReady held low indefinitely stalls only that channel; the other channel keeps working.
- Reset mid-operation: all in-flight transactions are dropped and outputs return to reset values. A write commits only if its commit edge precedes reset assertion.
- AWprot and ARprot are unused and have no effect on behaviour.

Test Plan:
- Reset release: AWready/Wready/ARready are 0 during reset and 1 one cycle after rstn rises; Bvalid=Rvalid=0.
- Write then read, READ_LAT=1:
  - Write AW=0x10, W=0xDEADBEEF, Wstrb=0xF → Bvalid the cycle after both are captured.
  - Read AR=0x10 → Rvalid exactly 1 cycle after the handshake, Rdata=0xDEADBEEF.
- Channel skew and strobes:
  - W=0x11223344 with Wstrb=0x5 arrives 3 cycles before AW=0x20 over prior contents 0xAABBCCDD.
  - Wready drops after W capture; Bvalid follows AW capture.
  - Readback = 0xAA22CC44.
- Latency and backpressure at READ_LAT=4:
  - Rvalid 4 cycles after AR; with RReady held low 5 cycles, Rdata stays stable and ARready stays 0.
  - With Bready held low, Bvalid persists and AWready=0 throughout.
- Aliasing and collision:
  - Write 0x5 to address 0x1000 (ADDR_BITS=10); a read of 0x0 returns 0x5.
  - Read and write to the same word committing on the same edge → read returns the old value.
- Reset mid-read: rstn pulsed while in R_WAIT → Rvalid never asserts, ARready=1 after release, memory contents unchanged.
